reimu_hit_detect: RTL and testbench

Collision stage directly upstream of the player life counter: once per video frame it serially scans the enemy-bullet table, compares each live bullet against Reimu's square hitbox, and emits a single-cycle `shot` pulse that drives the life counter's `shot` input. A per-frame cooldown suppresses repeat hits from the same bullet cluster. An optional output retires the bullet that hit.

---
 rtl/reimu_hit_detect.sv | 157 +++++++++++++++
 tb/tb_reimu_hit_detect.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reimu_hit_detect.sv
// reimu_hit_detect: once per frame, serially scans the enemy-bullet table against Reimu's square hitbox.
// Optional feature macro HIT_CLEAR_EN: emit a bullet_clr retire pulse alongside each reported hit.
module reimu_hit_detect #(
    parameter int N_BULLET    = 16,
    parameter int IDX_W       = 4,
    parameter int HIT_R       = 4,
    parameter int COOLDOWN_FR = 4
) (
    input  logic             clk_22,
    input  logic             rst_n,
    input  logic             gamestart,
    input  logic             frame_tick,
    input  logic [9:0]       reimu_x,
    input  logic [9:0]       reimu_y,
    input  logic             reimu_vuln,
    output logic [IDX_W-1:0] bullet_idx,
    input  logic             bullet_valid,
    input  logic [9:0]       bullet_x,
    input  logic [9:0]       bullet_y,
    output logic             busy,
    output logic             shot,
    output logic [IDX_W-1:0] hit_idx,
    output logic             bullet_clr
);
    localparam int               CD_W     = (COOLDOWN_FR > 0) ? $clog2(COOLDOWN_FR + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BULLET - 1);
    localparam logic [CD_W-1:0]  CD_LOAD  = CD_W'(COOLDOWN_FR);
    localparam logic [10:0]      HIT_R_W  = 11'(HIT_R);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, REPORT} state_t;

    state_t           state_q;
    logic [9:0]       rx_q, ry_q;
    logic             vuln_q;
    logic             hit_found_q;
    logic [IDX_W-1:0] hit_k_q;
    logic             rd_vld_q;
    logic [IDX_W-1:0] rd_k_q;
    logic [CD_W-1:0]  cooldown_q;
    logic [IDX_W-1:0] bullet_idx_q, hit_idx_q;
    logic             busy_q, shot_q;

    logic signed [10:0] dx_d, dy_d;
    logic [10:0]        adx_d, ady_d;
    logic               hit_now_d, found_d, report_d;
    logic [IDX_W-1:0]   found_k_d;
    logic [CD_W-1:0]    cd_dec_d;

    // 11-bit signed differences so bullets near 0/1023 never alias across the screen edge
    always_comb begin
        dx_d      = $signed({1'b0, bullet_x}) - $signed({1'b0, rx_q});
        dy_d      = $signed({1'b0, bullet_y}) - $signed({1'b0, ry_q});
        adx_d     = dx_d[10] ? $unsigned(-dx_d) : $unsigned(dx_d);
        ady_d     = dy_d[10] ? $unsigned(-dy_d) : $unsigned(dy_d);
        hit_now_d = rd_vld_q && bullet_valid && (adx_d <= HIT_R_W) && (ady_d <= HIT_R_W);
        found_d   = hit_found_q || hit_now_d;
        found_k_d = hit_found_q ? hit_k_q : rd_k_q;
        report_d  = found_d && vuln_q && (cooldown_q == '0);
        cd_dec_d  = (cooldown_q != '0) ? cooldown_q - 1'b1 : '0;
    end

    always_ff @(posedge clk_22 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rx_q         <= '0;
            ry_q         <= '0;
            vuln_q       <= 1'b0;
            hit_found_q  <= 1'b0;
            hit_k_q      <= '0;
            rd_vld_q     <= 1'b0;
            rd_k_q       <= '0;
            cooldown_q   <= '0;
            bullet_idx_q <= '0;
            hit_idx_q    <= '0;
            busy_q       <= 1'b0;
            shot_q       <= 1'b0;
        end else if (gamestart) begin
            state_q      <= IDLE;
            hit_found_q  <= 1'b0;
            hit_k_q      <= '0;
            rd_vld_q     <= 1'b0;
            rd_k_q       <= '0;
            cooldown_q   <= '0;
            bullet_idx_q <= '0;
            hit_idx_q    <= '0;
            busy_q       <= 1'b0;
            shot_q       <= 1'b0;
        end else begin
            shot_q   <= 1'b0;
            rd_vld_q <= (state_q == SCAN);
            rd_k_q   <= bullet_idx_q;
            if (hit_now_d && !hit_found_q) begin
                hit_found_q <= 1'b1;
                hit_k_q     <= rd_k_q;
            end
            case (state_q)
                IDLE: begin
                    if (frame_tick) begin
                        rx_q         <= reimu_x;
                        ry_q         <= reimu_y;
                        vuln_q       <= reimu_vuln;
                        hit_found_q  <= 1'b0;
                        bullet_idx_q <= '0;
                        busy_q       <= 1'b1;
                        state_q      <= SCAN;
                    end
                end
                SCAN: begin
                    if (bullet_idx_q == LAST_IDX) begin
                        bullet_idx_q <= '0;
                        state_q      <= DRAIN;
                    end else begin
                        bullet_idx_q <= bullet_idx_q + 1'b1;
                    end
                end
                DRAIN: begin
                    // last bullet's data arrives this cycle, so the decision folds it in directly
                    shot_q  <= report_d;
                    state_q <= REPORT;
                    if (report_d) begin
                        cooldown_q <= CD_LOAD;
                        hit_idx_q  <= found_k_d;
                    end else begin
                        cooldown_q <= cd_dec_d;
                    end
                end
                REPORT: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef HIT_CLEAR_EN
    logic clr_q;
    always_ff @(posedge clk_22 or negedge rst_n) begin
        if (!rst_n) begin
            clr_q <= 1'b0;
        end else if (gamestart) begin
            clr_q <= 1'b0;
        end else begin
            clr_q <= (state_q == DRAIN) && report_d;
        end
    end
    assign bullet_clr = clr_q;
`else
    assign bullet_clr = 1'b0;
`endif

    assign bullet_idx = bullet_idx_q;
    assign busy       = busy_q;
    assign shot       = shot_q;
    assign hit_idx    = hit_idx_q;

endmodule

// File: tb/tb_reimu_hit_detect.sv
// Bench for reimu_hit_detect: frame-timeline reference model plus directed and randomized frames.
// Honours HIT_CLEAR_EN when the same macro is defined for the build.
module tb_reimu_hit_detect;
    localparam int N    = 16;
    localparam int R    = 4;
    localparam int CDFR = 4;
`ifdef HIT_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic       clk_22 = 1'b0;
    logic       rst_n = 1'b0;
    logic       gamestart = 1'b0;
    logic       frame_tick = 1'b0;
    logic [9:0] reimu_x = '0, reimu_y = '0;
    logic       reimu_vuln = 1'b1;
    logic [3:0] bullet_idx;
    logic       bullet_valid = 1'b0;
    logic [9:0] bullet_x = '0, bullet_y = '0;
    logic       busy, shot, bullet_clr;
    logic [3:0] hit_idx;

    reimu_hit_detect dut (
        .clk_22(clk_22), .rst_n(rst_n), .gamestart(gamestart), .frame_tick(frame_tick),
        .reimu_x(reimu_x), .reimu_y(reimu_y), .reimu_vuln(reimu_vuln),
        .bullet_idx(bullet_idx), .bullet_valid(bullet_valid),
        .bullet_x(bullet_x), .bullet_y(bullet_y),
        .busy(busy), .shot(shot), .hit_idx(hit_idx), .bullet_clr(bullet_clr)
    );

    always #5 clk_22 = ~clk_22;

    // bullet table with one-cycle registered read
    logic       tab_v [N];
    logic [9:0] tab_x [N];
    logic [9:0] tab_y [N];
    always @(posedge clk_22) begin
        bullet_valid <= tab_v[bullet_idx];
        bullet_x     <= tab_x[bullet_idx];
        bullet_y     <= tab_y[bullet_idx];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // lowest-index valid bullet inside the inclusive square hitbox
    function automatic void eval_table(input int rx, input int ry, output bit hit, output int k);
        int dx, dy;
        hit = 1'b0;
        k   = 0;
        for (int i = N - 1; i >= 0; i--) begin
            dx = int'(tab_x[i]) - rx;
            dy = int'(tab_y[i]) - ry;
            if (dx < 0) dx = -dx;
            if (dy < 0) dy = -dy;
            if (tab_v[i] && dx <= R && dy <= R) begin
                hit = 1'b1;
                k   = i;
            end
        end
    endfunction

    // reference model: phase p means cycle T+p after the accepted tick at edge T
    int phase = 0;
    int cd = 0;
    bit m_hit, m_vuln;
    int m_k;
    int e_busy = 0, e_shot = 0, e_clr = 0, e_hidx = 0, e_idx = 0;
    bit e_idx_vld = 1'b0;
    always @(posedge clk_22 or negedge rst_n) begin
        if (!rst_n || gamestart) begin
            phase = 0; cd = 0; e_hidx = 0;
            e_busy = 0; e_shot = 0; e_clr = 0; e_idx = 0; e_idx_vld = 1'b1;
        end else begin
            e_shot = 0;
            e_clr  = 0;
            if (phase == 0) begin
                if (frame_tick) begin
                    phase  = 1;
                    eval_table(int'(reimu_x), int'(reimu_y), m_hit, m_k);
                    m_vuln = reimu_vuln;
                    e_busy = 1;
                end
            end else begin
                phase++;
            end
            if (phase == 19) begin
                phase  = 0;
                e_busy = 0;
            end
            e_idx_vld = (phase >= 1 && phase <= N);
            e_idx     = phase - 1;
            if (phase == N + 2) begin
                if (m_hit && m_vuln && cd == 0) begin
                    e_shot = 1;
                    e_clr  = CLR_EN ? 1 : 0;
                    cd     = CDFR;
                    e_hidx = m_k;
                end else if (cd > 0) begin
                    cd--;
                end
            end
        end
    end

    always @(negedge clk_22) begin
        chk("cyc_busy", int'(busy), e_busy);
        chk("cyc_shot", int'(shot), e_shot);
        chk("cyc_clr", int'(bullet_clr), e_clr);
        chk("cyc_hit_idx", int'(hit_idx), e_hidx);
        if (e_idx_vld) chk("cyc_bullet_idx", int'(bullet_idx), e_idx);
    end

    task automatic clr_table();
        for (int i = 0; i < N; i++) begin
            tab_v[i] = 1'b0;
            tab_x[i] = 10'd512;
            tab_y[i] = 10'd512;
        end
    endtask

    task automatic set_b(input int k, input int x, input int y);
        tab_v[k] = 1'b1;
        tab_x[k] = 10'(x);
        tab_y[k] = 10'(y);
    endtask

    task automatic do_gs();
        @(negedge clk_22) gamestart = 1'b1;
        @(negedge clk_22) gamestart = 1'b0;
    endtask

    task automatic set_reimu(input int x, input int y, input bit v);
        reimu_x = 10'(x); reimu_y = 10'(y); reimu_vuln = v;
    endtask

    task automatic run_frame(input int dup_at, output int nshot, output int shot_off,
                             output int nbusy, output int nclr);
        nshot = 0; shot_off = -1; nbusy = 0; nclr = 0;
        @(negedge clk_22) frame_tick = 1'b1;
        for (int off = 1; off <= 20; off++) begin
            @(negedge clk_22);
            frame_tick = (off == dup_at);
            if (shot) begin nshot++; shot_off = off; end
            if (busy) nbusy++;
            if (bullet_clr) nclr++;
        end
        frame_tick = 1'b0;
    endtask

    int ns, so, nb, nc, cnt;

    initial begin
        clr_table();
        repeat (2) @(negedge clk_22);
        chk("rst_busy", int'(busy), 0);
        chk("rst_shot", int'(shot), 0);
        chk("rst_clr", int'(bullet_clr), 0);
        chk("rst_bullet_idx", int'(bullet_idx), 0);
        chk("rst_hit_idx", int'(hit_idx), 0);
        #1 rst_n = 1'b1;

        set_reimu(100, 100, 1); set_b(5, 104, 96);
        run_frame(0, ns, so, nb, nc);
        chk("basic_nshot", ns, 1);
        chk("basic_offset", so, 18);
        chk("basic_hit_idx", int'(hit_idx), 5);
        chk("basic_busy_cycles", nb, 18);
        chk("basic_clr", nc, CLR_EN ? 1 : 0);

        do_gs(); chk("gs_hit_idx", int'(hit_idx), 0);
        clr_table(); set_b(5, 105, 100);
        run_frame(0, ns, so, nb, nc); chk("edge_x5_nshot", ns, 0);
        do_gs(); clr_table(); set_b(5, 96, 104);
        run_frame(0, ns, so, nb, nc); chk("edge_96_104_nshot", ns, 1);
        do_gs(); clr_table(); set_reimu(0, 0, 1); set_b(7, 3, 3);
        run_frame(0, ns, so, nb, nc); chk("origin_nshot", ns, 1);
        chk("origin_hit_idx", int'(hit_idx), 7);
        do_gs(); clr_table(); set_b(2, 1023, 1023); set_b(4, 1022, 2);
        run_frame(0, ns, so, nb, nc); chk("nowrap_nshot", ns, 0);

        do_gs(); clr_table(); set_reimu(200, 300, 1); set_b(3, 198, 303); set_b(9, 200, 300);
        run_frame(0, ns, so, nb, nc);
        chk("two_hits_nshot", ns, 1);
        chk("two_hits_hit_idx", int'(hit_idx), 3);

        do_gs(); clr_table(); set_b(11, 202, 297);
        for (int f = 1; f <= 6; f++) begin
            run_frame(0, ns, so, nb, nc);
            chk($sformatf("cooldown_f%0d", f), ns, (f == 1 || f == 6) ? 1 : 0);
        end

        do_gs(); set_reimu(200, 300, 0);
        run_frame(0, ns, so, nb, nc); chk("invuln_nshot", ns, 0);
        set_reimu(200, 300, 1);
        run_frame(0, ns, so, nb, nc); chk("after_invuln_nshot", ns, 1);

        do_gs();
        run_frame(5, ns, so, nb, nc);
        chk("dup_tick_nshot", ns, 1);
        chk("dup_tick_offset", so, 18);
        chk("dup_tick_busy", nb, 18);

        // tick arriving in the first idle cycle is accepted and starts a new scan
        run_frame(19, ns, so, nb, nc);
        chk("retick_busy", nb, 19);
        repeat (20) @(negedge clk_22);

        @(negedge clk_22) frame_tick = 1'b1;
        @(negedge clk_22) frame_tick = 1'b0;
        repeat (7) @(negedge clk_22);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_bullet_idx", int'(bullet_idx), 0);
        chk("async_rst_shot", int'(shot), 0);
        repeat (2) @(negedge clk_22);
        #1 rst_n = 1'b1;
        cnt = 0;
        repeat (15) begin @(negedge clk_22); if (shot) cnt++; end
        chk("aborted_rst_nshot", cnt, 0);
        run_frame(0, ns, so, nb, nc); chk("post_rst_nshot", ns, 1);

        @(negedge clk_22) frame_tick = 1'b1;
        @(negedge clk_22) frame_tick = 1'b0;
        repeat (7) @(negedge clk_22);
        gamestart = 1'b1;
        @(negedge clk_22) gamestart = 1'b0;
        chk("gs_mid_busy", int'(busy), 0);
        chk("gs_mid_bullet_idx", int'(bullet_idx), 0);
        cnt = 0;
        repeat (15) begin @(negedge clk_22); if (shot) cnt++; end
        chk("aborted_gs_nshot", cnt, 0);
        run_frame(0, ns, so, nb, nc); chk("post_gs_nshot", ns, 1);

        for (int fr = 0; fr < 150; fr++) begin
            int rx, ry;
            if ($urandom_range(0, 9) == 0) do_gs();
            rx = int'($urandom_range(0, 1023));
            ry = int'($urandom_range(0, 1023));
            set_reimu(rx, ry, $urandom_range(0, 4) != 0);
            for (int i = 0; i < N; i++) begin
                tab_v[i] = ($urandom_range(0, 9) < 2);
                tab_x[i] = 10'((rx + int'($urandom_range(0, 14)) - 7) & 1023);
                tab_y[i] = 10'((ry + int'($urandom_range(0, 14)) - 7) & 1023);
            end
            run_frame(($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 18)) : 0, ns, so, nb, nc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
